ad_sample_packer: RTL
=====================

Name: ad_sample_packer

Overview:
- Downstream stage of the AD9220 capture block; consumes its 12-bit parallel sample output.
- Decimates samples at a fixed rate and buffers them in a small FIFO.
- Packs each sample into two tagged bytes and hands them to the UART transmitter over a valid/ready byte handshake.
- Decouples ADC sample timing from UART byte throughput; reports FIFO occupancy and overflow.

Parameters:
- SAMPLE_DIV, 5000, clk cycles between captured samples (≥4).
- FIFO_DEPTH, 16, FIFO entries of 12 bits; power of two, ≥2.
- SYNC_NIBBLE, 4'hA, tag placed in the upper nibble of every high byte.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- sample_en  in  1  enables decimation and capture.
- ad_data  in  12  sample word from the AD9220 capture stage.
- tx_data  out  8  byte to the UART transmitter.
- tx_data_valid  out  1  tx_data holds a valid byte.
- tx_data_ready  in  1  UART accepts the byte.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; set when a sample is dropped.

Behaviour:
- Clock and reset:
  - One clock: clk. Reset is synchronous and active-high on rst.
  - Reset values: tx_data=0, tx_data_valid=0, fifo_level=0, overflow=0, div counter=0, FSM=IDLE, FIFO pointers=0.
  - rst asserted mid-frame: the partial frame is discarded and the FIFO is emptied. Outputs reach reset values at the first edge with rst=1.
- Input register:
  - ad_data is registered every cycle (1 stage) into ad_q.
  - Only ad_q is written to the FIFO.
- Decimation:
  - div_cnt runs 0..SAMPLE_DIV-1 and wraps to 0 while sample_en=1.
  - div_cnt is forced to 0 while sample_en=0.
  - The cycle with div_cnt==SAMPLE_DIV-1 and sample_en=1 is a strobe. It writes ad_q into the FIFO.
  - First strobe occurs SAMPLE_DIV cycles after sample_en rises.
- FIFO:
  - Synchronous write and read; pointers wrap modulo FIFO_DEPTH.
  - fifo_level = writes − pops and updates the cycle after each event.
  - Write and pop in the same cycle: level is unchanged.
- Full condition:
  - Strobe while fifo_level==FIFO_DEPTH: the sample is dropped and overflow is set.
  - This holds even if a pop occurs in the same cycle; full is evaluated before the pop.
  - overflow is cleared only by rst.
- FSM states: IDLE, SEND_HI, SEND_LO.
  - IDLE: if FIFO is non-empty, pop one word w. Load tx_data={SYNC_NIBBLE, w[11:8]}, assert tx_data_valid, go to SEND_HI.
  - SEND_HI: hold tx_data and valid until tx_data_valid&&tx_data_ready at an edge. On that edge, load tx_data=w[7:0] with valid still 1 and go to SEND_LO.
  - SEND_LO: on handshake, go to IDLE with tx_data_valid=0.
  - Back-to-back frames pass through IDLE for exactly one cycle: valid is low for 1 cycle between frames.
- Handshake rules:
  - tx_data is stable while tx_data_valid=1 and ready=0.
  - valid never drops without a handshake, except on rst.
  - ready is ignored while valid=0.
- Latency:
  - Strobe at edge E writes the FIFO.
  - The FSM pops at E+1, and tx_data_valid=1 with the high byte after E+1.
- sample_en deasserted mid-frame: the current frame completes and the FIFO keeps draining; no new captures occur.
- Width rules: the low byte carries w[7:0] exactly. The high byte tag is constant; no checksum.

Test Plan:
- Basic frame: SAMPLE_DIV=8, ad_data=12'h5C3, ready tied 1, sample_en=1 → first strobe 8 cycles after enable. Bytes 0xA5 then 0xC3 are transferred in consecutive cycles. valid is low for 1 cycle after each frame. fifo_level returns to 0.
- Backpressure: ready=0 for 20 cycles while valid=1 → tx_data stays 0xA5. Then ready=1 → 0xA5 is accepted, followed by 0xC3 with no byte lost or repeated.
- Overflow: FIFO_DEPTH=4, ready=0, sample_en=1 with ad_data ramping 0,1,2,… → fifo_level saturates at 4 and overflow=1 after the 6th strobe. (The 1st sample moves to the FSM, so the 6th strobe is the first drop.) Releasing ready yields samples 0..4 in order.
- Simultaneous write and pop: align a strobe with an IDLE pop → fifo_level is unchanged that cycle and byte order is preserved.
- sample_en drop mid-frame: drop while in SEND_HI → the frame completes and remaining entries drain. No further strobes occur and div_cnt reads 0.
- Reset mid-operation: rst=1 for 1 cycle in SEND_LO with 3 words queued → valid=0, fifo_level=0, overflow=0 after the edge. The next frame starts with a high byte.

Source files
------------

// File: rtl/ad_sample_packer.sv
// Decimates 12-bit ADC samples into a small FIFO and streams each one as two
// tagged bytes ({SYNC_NIBBLE, w[11:8]} then w[7:0]) over a valid/ready handshake.
module ad_sample_packer #(
   parameter int          SAMPLE_DIV  = 5000,
   parameter int          FIFO_DEPTH  = 16,
   parameter logic [3:0]  SYNC_NIBBLE = 4'hA
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          sample_en,
   input  logic [11:0]                   ad_data,
   output logic [7:0]                    tx_data,
   output logic                          tx_data_valid,
   input  logic                          tx_data_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow
);

   localparam int DIV_W = $clog2(SAMPLE_DIV);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, SEND_HI = 2'd1, SEND_LO = 2'd2} state_t;

   state_t             state;
   state_t             state_next;
   logic [11:0]        ad_q;
   logic [DIV_W-1:0]   div_cnt;
   logic               strobe;
   logic               full;
   logic               empty;
   logic               wr_en;
   logic               pop;
   logic [11:0]        mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [11:0]        rd_word;
   logic [7:0]         lo_byte;
   logic [7:0]         lo_byte_next;
   logic [7:0]         tx_data_next;
   logic               valid_next;

   assign strobe  = sample_en && (div_cnt == DIV_W'(SAMPLE_DIV - 1));
   assign full    = (fifo_level == LVL_W'(FIFO_DEPTH));
   assign empty   = (fifo_level == LVL_W'(0));
   // Full is judged before any same-cycle pop, so a strobe at full always drops.
   assign wr_en   = strobe && !full;
   assign rd_word = mem[rd_ptr];

   // Input register and decimation counter
   always_ff @(posedge clk) begin
      if (rst) begin
         ad_q    <= 12'd0;
         div_cnt <= '0;
      end else begin
         ad_q <= ad_data;
         if (!sample_en || strobe) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= ad_q;
      end
   end

   // FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         overflow   <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({wr_en, pop})
            2'b10:   fifo_level <= fifo_level + LVL_W'(1);
            2'b01:   fifo_level <= fifo_level - LVL_W'(1);
            default: fifo_level <= fifo_level;
         endcase
         if (strobe && full) begin
            overflow <= 1'b1;
         end
      end
   end

   // Frame FSM state and registered byte outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         tx_data       <= 8'd0;
         tx_data_valid <= 1'b0;
         lo_byte       <= 8'd0;
      end else begin
         state         <= state_next;
         tx_data       <= tx_data_next;
         tx_data_valid <= valid_next;
         lo_byte       <= lo_byte_next;
      end
   end

   // Frame FSM next-state and next-output logic
   always_comb begin
      state_next   = state;
      tx_data_next = tx_data;
      valid_next   = tx_data_valid;
      lo_byte_next = lo_byte;
      pop          = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop          = 1'b1;
               tx_data_next = {SYNC_NIBBLE, rd_word[11:8]};
               lo_byte_next = rd_word[7:0];
               valid_next   = 1'b1;
               state_next   = SEND_HI;
            end else begin
               valid_next   = 1'b0;
               state_next   = IDLE;
            end
         end
         SEND_HI: begin
            if (tx_data_ready) begin
               tx_data_next = lo_byte;
               state_next   = SEND_LO;
            end else begin
               state_next   = SEND_HI;
            end
         end
         SEND_LO: begin
            if (tx_data_ready) begin
               valid_next = 1'b0;
               state_next = IDLE;
            end else begin
               state_next = SEND_LO;
            end
         end
         default: begin
            valid_next = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

endmodule
